// File: rtl/weight_optimization.sv
// Backpropagation delta engine for a 5-input, 3-output sigmoid layer with an in-place 3x5 weight file.
// Build option: define WEIGHT_OPT_SATURATE_EN to clamp register writes instead of wrapping them.
module weight_optimization #(
  parameter int W        = 10,
  parameter int FRAC     = 6,
  parameter int LR_SHIFT = 2
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic         WE,
  input  logic         In,
  input  logic [W-1:0] out1_actual [0:2],
  input  logic [W-1:0] out1_cal    [0:2],
  input  logic [W-1:0] out0_cal    [0:4],
  output logic [W-1:0] delta1      [0:2],
  output logic [W-1:0] delta0      [0:4]
);

  // Wide enough that no intermediate product or sum can overflow
  localparam int AW = 4 * W + 8;
  localparam logic signed [AW-1:0] ONE   = AW'(1) <<< FRAC;
  localparam logic [W-1:0]         ONE_W = W'(1) << FRAC;

  function automatic logic signed [AW-1:0] sx(input logic [W-1:0] v);
    return {{(AW - W){v[W-1]}}, v};
  endfunction

  function automatic logic [W-1:0] reduce(input logic signed [AW-1:0] v);
`ifdef WEIGHT_OPT_SATURATE_EN
    logic signed [AW-1:0] max_v;
    logic signed [AW-1:0] min_v;
    max_v = (AW'(1) <<< (W - 1)) - AW'(1);
    min_v = -(AW'(1) <<< (W - 1));
    if (v > max_v)      return max_v[W-1:0];
    else if (v < min_v) return min_v[W-1:0];
    else                return v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  logic [W-1:0] wt [0:2][0:4];

  logic signed [AW-1:0] e_k  [0:2];
  logic signed [AW-1:0] d_k  [0:2];
  logic signed [AW-1:0] s_j  [0:4];
  logic signed [AW-1:0] g_j  [0:4];
  logic [W-1:0]         d1_next [0:2];
  logic [W-1:0]         d0_next [0:4];
  logic [W-1:0]         wt_next [0:2][0:4];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      e_k[k]     = sx(out1_actual[k]) - sx(out1_cal[k]);
      d_k[k]     = (sx(out1_cal[k]) * (ONE - sx(out1_cal[k]))) >>> FRAC;
      d1_next[k] = reduce((e_k[k] * d_k[k]) >>> FRAC);
    end
    // Hidden deltas see the registered delta1 and the weights before this edge's update
    for (int j = 0; j < 5; j++) begin
      s_j[j] = '0;
      for (int k = 0; k < 3; k++)
        s_j[j] = s_j[j] + ((sx(wt[k][j]) * sx(delta1[k])) >>> FRAC);
      g_j[j]     = (sx(out0_cal[j]) * (ONE - sx(out0_cal[j]))) >>> FRAC;
      d0_next[j] = reduce((s_j[j] * g_j[j]) >>> FRAC);
    end
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 5; j++)
        wt_next[k][j] = reduce(sx(wt[k][j]) +
                               (((sx(delta1[k]) * sx(out0_cal[j])) >>> FRAC) >>> LR_SHIFT));
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < 3; k++) delta1[k] <= '0;
      for (int j = 0; j < 5; j++) delta0[j] <= '0;
    end else if (In) begin
      for (int k = 0; k < 3; k++) delta1[k] <= d1_next[k];
      for (int j = 0; j < 5; j++) delta0[j] <= d0_next[j];
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 5; j++)
          wt[k][j] <= ONE_W;
    end else if (WE) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 5; j++)
          wt[k][j] <= wt_next[k][j];
    end
  end

endmodule

// File: tb/tb_weight_optimization.sv
// Directed bench for weight_optimization: steady-state vector table plus latency, hold, learning and reset sequences.
module tb_weight_optimization;
  localparam int W = 10;

  logic         Clock = 1'b0;
  logic         Rst, WE, In;
  logic [W-1:0] out1_actual [0:2];
  logic [W-1:0] out1_cal    [0:2];
  logic [W-1:0] out0_cal    [0:4];
  logic [W-1:0] delta1      [0:2];
  logic [W-1:0] delta0      [0:4];

  int n_pass = 0;
  int n_total = 0;

  weight_optimization #(.W(W), .FRAC(6), .LR_SHIFT(2)) dut (
    .Clock(Clock), .Rst(Rst), .WE(WE), .In(In),
    .out1_actual(out1_actual), .out1_cal(out1_cal), .out0_cal(out0_cal),
    .delta1(delta1), .delta0(delta0)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string name;
    int    act;
    int    cal;
    int    hid;
    int    exp_d1;
    int    exp_d0;
  } vec_t;

  vec_t vecs [5];

  task automatic set_inputs(input int act, input int cal, input int hid);
    for (int k = 0; k < 3; k++) begin
      out1_actual[k] = W'(act);
      out1_cal[k]    = W'(cal);
    end
    for (int j = 0; j < 5; j++) out0_cal[j] = W'(hid);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_d1(input string name, input int exp);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (int'($signed(delta1[k])) == exp) n_pass++;
      else $display("FAIL %s delta1[%0d]: got %0d expected %0d", name, k, $signed(delta1[k]), exp);
    end
  endtask

  task automatic check_d0(input string name, input int exp);
    for (int j = 0; j < 5; j++) begin
      n_total++;
      if (int'($signed(delta0[j])) == exp) n_pass++;
      else $display("FAIL %s delta0[%0d]: got %0d expected %0d", name, j, $signed(delta0[j]), exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{"basic",    64,   32, 32,   8,    6};
    vecs[1] = '{"negative",  1,  -25, 32, -15,  -12};
    vecs[2] = '{"zero_err", 32,   32,  0,   0,    0};
    vecs[3] = '{"neg_err",   0,   16, 16,  -3,   -2};
`ifdef WEIGHT_OPT_SATURATE_EN
    vecs[4] = '{"saturate", 511, -512, 32, -512, -384};
`else
    vecs[4] = '{"wrap",     511, -512, 32,   72,   54};
`endif

    Rst = 1'b1; WE = 1'b0; In = 1'b1;
    set_inputs(64, 32, 32);
    tick(); tick();
    check_d1("reset_hold", 0);
    check_d0("reset_hold", 0);
    Rst = 1'b0;
    #1;

    // Steady state: two edges settle delta0; weights stay at ONE since WE=0
    for (int i = 0; i < 5; i++) begin
      In = 1'b1; WE = 1'b0;
      set_inputs(vecs[i].act, vecs[i].cal, vecs[i].hid);
      tick(); tick();
      check_d1(vecs[i].name, vecs[i].exp_d1);
      check_d0(vecs[i].name, vecs[i].exp_d0);
    end

    // Latency: delta1 after one edge, delta0 only after the second
    do_reset();
    In = 1'b1; WE = 1'b0;
    set_inputs(64, 32, 32);
    tick();
    check_d1("latency_e1", 8);
    check_d0("latency_e1", 0);
    tick();
    check_d0("latency_e2", 6);

    // Hold with In=0 while inputs change
    In = 1'b0;
    set_inputs(64, 0, 0);
    tick(); tick();
    check_d1("hold", 8);
    check_d0("hold", 6);

    // Learning: 63 updates bring weights to 127, delta0 must not move with In=0
    set_inputs(64, 32, 32);
    WE = 1'b1;
    repeat (63) tick();
    check_d0("learn_hold", 6);
    // Joint edge: delta0 from weights 127 -> s=45 -> 11; weights then reach 128
    In = 1'b1;
    tick();
    check_d0("pre_update", 11);
    check_d1("pre_update", 8);
    WE = 1'b0;
    tick();
    check_d0("learned", 12);
    tick();
    check_d0("weights_held", 12);

    // Asynchronous reset between edges
    #2;
    Rst = 1'b1;
    #1;
    check_d1("async_rst", 0);
    check_d0("async_rst", 0);
    tick();
    Rst = 1'b0;
    #1;
    // Weights must be back at ONE: delta0 returns to 6, not 12
    In = 1'b1;
    tick(); tick();
    check_d0("weights_reset", 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
